sobel_window_gen: RTL

Raster-to-window front end for the Sobel edge path. It accepts one 8-bit grayscale pixel per valid cycle in row-major order and keeps two line buffers plus a 3x3 shift window. For every pixel that completes a full 3x3 neighbourhood, it presents the window on `p11..p33` with a one-cycle `win_valid`. It sits directly upstream of the Sobel kernel and forwards a valid/last flag delayed to line up with the kernel's registered edge output.

---
 rtl/sobel_pkg.sv | 13 +
 rtl/sobel_line_buffer.sv | 25 ++
 rtl/sobel_window_gen.sv | 128 ++++++++++++
 3 files changed

// File: rtl/sobel_pkg.sv
// Shared types and defaults for the Sobel edge path (window generator and kernel wrapper).
package sobel_pkg;

  localparam int PIX_W = 8;
  typedef logic [PIX_W-1:0] pixel_t;

  localparam int DEF_IMG_WIDTH  = 640;
  localparam int DEF_IMG_HEIGHT = 480;

  // Cycles from window presentation to the kernel's registered out_pixel.
  localparam int KERNEL_LAT = 4;

endpackage

// File: rtl/sobel_line_buffer.sv
// One raster line of pixels: combinational read, synchronous write.
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH = DEF_IMG_WIDTH
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [$clog2(IMG_WIDTH)-1:0] addr,
  input  pixel_t                       wdata,
  output pixel_t                       rdata
);

  pixel_t mem [IMG_WIDTH];

  // Contents are never cleared; stale rows are masked downstream by the row gate.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/sobel_window_gen.sv
// Raster-to-3x3-window front end for the Sobel kernel, with a valid/last delay line
// matched to the kernel's output latency.
module sobel_window_gen
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int KERNEL_LAT = sobel_pkg::KERNEL_LAT
) (
  input  logic   clk,
  input  logic   rst_n,
  input  pixel_t pix_in,
  input  logic   pix_valid,
  input  logic   sof,
  output pixel_t p11,
  output pixel_t p12,
  output pixel_t p13,
  output pixel_t p21,
  output pixel_t p22,
  output pixel_t p23,
  output pixel_t p31,
  output pixel_t p32,
  output pixel_t p33,
  output logic   win_valid,
  output logic   win_last,
  output logic   edge_valid,
  output logic   edge_last
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  logic [CW-1:0] col, cur_col;
  logic [RW-1:0] row, cur_row;
  logic          interior, frame_end;
  pixel_t        lb1_rd, lb2_rd;

  logic [KERNEL_LAT-1:0] vld_sr, last_sr;

  // A qualified sof forces this pixel to (0,0) regardless of the running counters.
  always_comb begin
    cur_col = col;
    cur_row = row;
    if (pix_valid && sof) begin
      cur_col = '0;
      cur_row = '0;
    end
  end

  assign interior  = (cur_row >= RW'(2)) && (cur_col >= CW'(2));
  assign frame_end = (cur_row == ROW_LAST) && (cur_col == COL_LAST);

  sobel_line_buffer #(.IMG_WIDTH(IMG_WIDTH)) u_lb1 (
    .clk   (clk),
    .we    (pix_valid),
    .addr  (cur_col),
    .wdata (pix_in),
    .rdata (lb1_rd)
  );

  // Chained: LB2 captures LB1's old entry on the same edge LB1 takes the new pixel.
  sobel_line_buffer #(.IMG_WIDTH(IMG_WIDTH)) u_lb2 (
    .clk   (clk),
    .we    (pix_valid),
    .addr  (cur_col),
    .wdata (lb1_rd),
    .rdata (lb2_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (pix_valid) begin
      if (cur_col == COL_LAST) begin
        col <= '0;
        row <= (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
      end else begin
        col <= cur_col + CW'(1);
        row <= cur_row;
      end
    end
  end

  // Window stage: rows shift left, new right column from LB2 / LB1 / live pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p11 <= '0; p12 <= '0; p13 <= '0;
      p21 <= '0; p22 <= '0; p23 <= '0;
      p31 <= '0; p32 <= '0; p33 <= '0;
    end else if (pix_valid) begin
      p11 <= p12; p12 <= p13; p13 <= lb2_rd;
      p21 <= p22; p22 <= p23; p23 <= lb1_rd;
      p31 <= p32; p32 <= p33; p33 <= pix_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_valid <= 1'b0;
      win_last  <= 1'b0;
    end else begin
      win_valid <= pix_valid && interior;
      win_last  <= pix_valid && interior && frame_end;
    end
  end

  // Kernel-latency delay line; cleared on reset so in-flight pulses are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_sr  <= '0;
      last_sr <= '0;
    end else begin
      vld_sr[0]  <= win_valid;
      last_sr[0] <= win_last;
      for (int i = 1; i < KERNEL_LAT; i++) begin
        vld_sr[i]  <= vld_sr[i-1];
        last_sr[i] <= last_sr[i-1];
      end
    end
  end

  assign edge_valid = vld_sr[KERNEL_LAT-1];
  assign edge_last  = last_sr[KERNEL_LAT-1];

endmodule
